// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl_if
// Description : Instruction-memory handshake bundle. The fetch controller is
//               the master: it drives a held chip-select plus address and gets
//               back a busy flag and the read word.
//   mem_cs    : request; held high for the whole transaction
//   mem_addr  : memory address, stable while mem_cs=1
//   mem_stall : memory busy (mem_cs & ~ack)
//   mem_dout  : read data, valid when mem_cs=1 and mem_stall=0
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_ctrl_if;
    logic        mem_cs;
    logic [31:0] mem_addr;
    logic        mem_stall;
    logic [31:0] mem_dout;

    modport master (
        output mem_cs,
        output mem_addr,
        input  mem_stall,
        input  mem_dout
    );

    modport slave (
        input  mem_cs,
        input  mem_addr,
        output mem_stall,
        output mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl
// Description : Fetch-side initiator for a slow instruction ROM. A PC miss
//               becomes a held cs/addr transaction; the acked word fills a
//               one-entry last-fetch buffer that serves repeated PCs without
//               touching memory. A hung memory trips a sticky timeout error.
// Ports       :
//   clk, rst             : clock, synchronous active-high reset
//   fetch_en, flush, pc  : CPU fetch request, abort, fetch byte address
//   inst, inst_valid     : instruction delivered this cycle (0 when invalid)
//   cpu_stall            : IF stage must hold pc
//   mem (master)         : memory handshake (cs/addr out, stall/dout in)
//   err                  : sticky timeout error (cleared only by rst)
//   addr_fault           : live transaction addresses beyond ADDR_WIDTH
//   hit_cnt, miss_cnt    : wrapping buffer-hit / transaction counters
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 32,
    parameter int WORD_ADDR  = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          fetch_en,
    input  wire logic          flush,
    input  wire logic [31:0]   pc,
    output logic      [31:0]   inst,
    output logic               inst_valid,
    output logic               cpu_stall,
    inst_fetch_ctrl_if.master  mem,
    output logic               err,
    output logic               addr_fault,
    output logic      [31:0]   hit_cnt,
    output logic      [31:0]   miss_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t          state_q,    state_d;
    logic            mem_cs_q,   mem_cs_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic            buf_valid_q, buf_valid_d;
    logic [31:0]     buf_tag_q,  buf_tag_d;
    logic [31:0]     buf_data_q, buf_data_d;
    logic            err_q,      err_d;
    logic [31:0]     hit_cnt_q,  hit_cnt_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;
    logic [TW-1:0]   tmo_q,      tmo_d;

    logic            hit;
    logic [31:0]     mapped_addr;

    // Buffer is only consulted when no transaction is in flight, so buf_tag
    // may already point at the pending PC while buf_data is still the old word.
    assign hit = fetch_en & buf_valid_q & (pc == buf_tag_q) &
                 (state_q == S_IDLE) & ~flush;

    assign mapped_addr = (WORD_ADDR != 0) ? {2'b00, pc[31:2]} : pc;

    assign inst_valid   = hit;
    assign inst         = hit ? buf_data_q : 32'd0;
    assign cpu_stall    = (fetch_en & ~hit) | (state_q == S_ERR);
    assign mem.mem_cs   = mem_cs_q;
    assign mem.mem_addr = mem_addr_q;
    assign err          = err_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;
    assign addr_fault   = mem_cs_q & (|(mem_addr_q >> ADDR_WIDTH));

    always_comb begin
        state_d     = state_q;
        mem_cs_d    = mem_cs_q;
        mem_addr_d  = mem_addr_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        err_d       = err_q;
        miss_cnt_d  = miss_cnt_q;
        tmo_d       = tmo_q;
        hit_cnt_d   = hit ? hit_cnt_q + 32'd1 : hit_cnt_q;

        if (flush && state_q != S_ERR) begin
            // Abort wins over a same-cycle ack: that word is dropped.
            state_d     = S_IDLE;
            mem_cs_d    = 1'b0;
            buf_valid_d = 1'b0;
            tmo_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_en && !hit) begin
                        state_d    = S_WAIT;
                        mem_cs_d   = 1'b1;
                        mem_addr_d = mapped_addr;
                        buf_tag_d  = pc;
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        tmo_d      = '0;
                    end
                end
                S_WAIT: begin
                    if (!mem.mem_stall) begin
                        // Returning to IDLE forces cs low for a cycle, which
                        // the memory needs to separate transactions.
                        state_d     = S_IDLE;
                        mem_cs_d    = 1'b0;
                        buf_data_d  = mem.mem_dout;
                        buf_valid_d = 1'b1;
                        tmo_d       = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                        if (tmo_d == TMO_LIMIT) begin
                            state_d  = S_ERR;
                            mem_cs_d = 1'b0;
                            err_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = S_ERR;
                    mem_cs_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_cs_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= 32'd0;
            buf_data_q  <= 32'd0;
            err_q       <= 1'b0;
            hit_cnt_q   <= 32'd0;
            miss_cnt_q  <= 32'd0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_cs_q    <= mem_cs_d;
            mem_addr_q  <= mem_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            err_q       <= err_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_ctrl
// Description : Directed self-checking bench for inst_fetch_ctrl with a slow
//               ROM model that acks on the 9th consecutive cs cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        cpu_stall;
    logic        err;
    logic        addr_fault;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    inst_fetch_ctrl_if mif ();

    inst_fetch_ctrl #(
        .ADDR_WIDTH (6),
        .TIMEOUT    (32),
        .WORD_ADDR  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .flush      (flush),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .cpu_stall  (cpu_stall),
        .mem        (mif),
        .err        (err),
        .addr_fault (addr_fault),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: counts consecutive cs-high cycles; cs low restarts latency.
    logic ack_en;
    int   cs_cnt;

    always @(posedge clk) begin
        if (rst || !mif.mem_cs) cs_cnt <= 0;
        else                    cs_cnt <= cs_cnt + 1;
    end

    assign mif.mem_stall = mif.mem_cs & ~(ack_en & (cs_cnt == 8));

    always_comb begin
        if (mif.mem_addr == 32'h1) mif.mem_dout = 32'h20080005;
        else                       mif.mem_dout = {mif.mem_addr[15:0], 16'hC0DE};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Ends on a falling edge with rst released and state freshly reset.
    task automatic do_reset();
        rst = 1'b1; fetch_en = 1'b0; flush = 1'b0; pc = 32'd0; ack_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    // CPU protocol: pc must not move while a transaction is outstanding.
    logic        prev_cs = 1'b0;
    logic [31:0] prev_pc = 32'd0;
    always begin
        @(negedge clk);
        #2;
        if (!rst && prev_cs && mif.mem_cs) chk("pc_stable", pc, prev_pc);
        prev_cs = mif.mem_cs & ~rst;
        prev_pc = pc;
    end

    initial begin
        rst = 1'b1; fetch_en = 1'b0; flush = 1'b0; pc = 32'd0; ack_en = 1'b1;
        tick(); tick(); #1;
        chk("rst_cs",      mif.mem_cs,   0);
        chk("rst_addr",    mif.mem_addr, 0);
        chk("rst_err",     err,          0);
        chk("rst_hit",     hit_cnt,      0);
        chk("rst_miss",    miss_cnt,     0);
        chk("rst_valid",   inst_valid,   0);
        chk("rst_stall",   cpu_stall,    0);
        chk("rst_fault",   addr_fault,   0);
        tick(); rst = 1'b0;

        // Cold miss: request cycle + 9 cs cycles, word delivered in cycle 11.
        fetch_en = 1'b1; pc = 32'h4; #1;
        chk("cold_c1_stall", cpu_stall,  1);
        chk("cold_c1_cs",    mif.mem_cs, 0);
        for (int i = 1; i <= 9; i++) begin
            tick(); #1;
            chk("cold_cs_high", mif.mem_cs, 1);
            if (i == 1) begin
                chk("cold_addr",  mif.mem_addr, 32'h1);
                chk("cold_fault", addr_fault,   0);
            end
        end
        chk("cold_c10_valid", inst_valid, 0);
        chk("cold_c10_stall", cpu_stall,  1);
        tick(); #1;
        chk("cold_c11_cs",    mif.mem_cs, 0);
        chk("cold_c11_valid", inst_valid, 1);
        chk("cold_c11_inst",  inst,       32'h20080005);
        chk("cold_c11_stall", cpu_stall,  0);
        chk("cold_miss_cnt",  miss_cnt,   1);

        // Two more hits on the same pc, then idle.
        tick(); #1;
        chk("hit2_valid", inst_valid, 1);
        chk("hit2_cs",    mif.mem_cs, 0);
        tick(); #1;
        chk("hit3_valid", inst_valid, 1);
        chk("hit3_inst",  inst,       32'h20080005);
        tick(); fetch_en = 1'b0; #1;
        chk("hit_cnt3",     hit_cnt,    3);
        chk("idle_stall",   cpu_stall,  0);
        chk("idle_inst",    inst,       0);

        // Flush together with a would-be hit: hit suppressed, no transaction.
        tick(); fetch_en = 1'b1; flush = 1'b1; pc = 32'h4; #1;
        chk("flhit_valid", inst_valid, 0);
        chk("flhit_stall", cpu_stall,  1);
        tick(); flush = 1'b0; #1;
        chk("flhit_cs",    mif.mem_cs, 0);
        chk("flhit_inval", inst_valid, 0);
        chk("flhit_hcnt",  hit_cnt,    3);

        // Sequential misses 0x0 then 0x4: one cs-low cycle between them.
        do_reset();
        fetch_en = 1'b1; pc = 32'h0; #1;
        for (int i = 1; i <= 9; i++) begin
            tick(); #1;
            chk("seq1_cs_high", mif.mem_cs, 1);
        end
        tick(); pc = 32'h4; #1;
        chk("seq_gap_cs",    mif.mem_cs, 0);
        chk("seq_gap_stall", cpu_stall,  1);
        tick(); #1;
        chk("seq2_cs",   mif.mem_cs,   1);
        chk("seq2_addr", mif.mem_addr, 32'h1);
        chk("seq_miss2", miss_cnt,     2);
        for (int i = 2; i <= 9; i++) tick();
        tick(); #1;
        chk("seq2_valid", inst_valid, 1);
        chk("seq2_inst",  inst,       32'h20080005);

        // Flush on the 5th cs cycle; the retry needs a full 9-cycle transaction.
        do_reset();
        fetch_en = 1'b1; pc = 32'h4; #1;
        for (int i = 1; i <= 4; i++) tick();
        tick(); flush = 1'b1; #1;
        chk("fl5_cs", mif.mem_cs, 1);
        tick(); flush = 1'b0; #1;
        chk("fl_after_cs",  mif.mem_cs,      0);
        chk("fl_buf_valid", dut.buf_valid_q, 0);
        chk("fl_stall",     cpu_stall,       1);
        for (int i = 1; i <= 9; i++) begin
            tick(); #1;
            chk("retry_cs_high", mif.mem_cs, 1);
            chk("retry_novalid", inst_valid, 0);
        end
        tick(); #1;
        chk("retry_valid", inst_valid, 1);
        chk("retry_inst",  inst,       32'h20080005);
        chk("retry_miss",  miss_cnt,   2);

        // Timeout: memory never acks.
        do_reset();
        ack_en = 1'b0;
        fetch_en = 1'b1; pc = 32'h8; #1;
        for (int i = 1; i <= 32; i++) begin
            tick(); #1;
            chk("tmo_cs_high", mif.mem_cs, 1);
        end
        chk("tmo_err_early", err, 0);
        tick(); #1;
        chk("tmo_err",   err,        1);
        chk("tmo_cs",    mif.mem_cs, 0);
        chk("tmo_stall", cpu_stall,  1);
        tick(); flush = 1'b1; #1;
        chk("err_flush_stall", cpu_stall, 1);
        tick(); flush = 1'b0; fetch_en = 1'b0; #1;
        chk("err_sticky",      err,        1);
        chk("err_stall_idle",  cpu_stall,  1);
        chk("err_cs",          mif.mem_cs, 0);
        do_reset(); #1;
        chk("rst_clr_err",   err,       0);
        chk("rst_clr_stall", cpu_stall, 0);
        chk("rst_clr_miss",  miss_cnt,  0);

        // Out-of-range address and miss counter wrap.
        tick();
        force dut.miss_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.miss_cnt_q;
        fetch_en = 1'b1; pc = 32'h400; #1;
        chk("wrap_preload", miss_cnt,   32'hFFFFFFFF);
        chk("fault_idle",   addr_fault, 0);
        tick(); #1;
        chk("fault_cs",   mif.mem_cs,   1);
        chk("fault_addr", mif.mem_addr, 32'h100);
        chk("fault_flag", addr_fault,   1);
        chk("wrap_zero",  miss_cnt,     0);
        for (int i = 2; i <= 9; i++) tick();
        tick(); #1;
        chk("fault_clear", addr_fault, 0);
        chk("fault_valid", inst_valid, 1);
        chk("fault_inst",  inst,       32'h0100C0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Initiator side of the slow instruction-memory handshake (cs/addr out, stall/dout back). It sits between the CPU IF stage and the instruction ROM. It converts a PC fetch request into a held cs/addr transaction and captures the word on acknowledge. A one-entry last-fetch buffer serves repeated PCs with no memory access, and a timeout flags a hung memory.

Parameters:
ADDR_WIDTH, 6, word-address bits the memory decodes; used only for the out-of-range flag.
TIMEOUT, 32, max cycles in WAIT before error; counter width is clog2(TIMEOUT+1).
WORD_ADDR, 1, 1: mem_addr = {2'b00, pc[31:2]}; 0: mem_addr = pc.

Ports:
clk  in  1  single clock, all state updates on posedge.
rst  in  1  synchronous, active-high reset.
fetch_en  in  1  CPU requests instruction at pc this cycle.
flush  in  1  abort any outstanding fetch and invalidate the buffer.
pc  in  32  fetch byte address; CPU holds it stable while cpu_stall=1.
inst  out  32  fetched instruction; 0 when inst_valid=0.
inst_valid  out  1  inst valid this cycle.
cpu_stall  out  1  IF must hold pc and stall.
mem_cs  out  1  memory request, registered.
mem_addr  out  32  memory address, registered, stable while mem_cs=1.
mem_stall  in  1  memory busy; equals mem_cs & ~ack.
mem_dout  in  32  memory data; valid when mem_cs=1 and mem_stall=0.
err  out  1  sticky timeout error.
addr_fault  out  1  mem_addr above ADDR_WIDTH range while mem_cs=1 (comb).
hit_cnt  out  32  buffer hits; wraps modulo 2^32.
miss_cnt  out  32  memory transactions started; wraps modulo 2^32.

Behaviour:
- Reset values: state=IDLE, mem_cs=0, mem_addr=0, buf_valid=0, buf_tag=0, buf_data=0, err=0, both counters 0, timeout counter 0.
- Hit (comb) = fetch_en & buf_valid & (pc==buf_tag) & state==IDLE & ~flush.
- Outputs (comb):
  - inst_valid=hit; inst=hit?buf_data:0.
  - cpu_stall = fetch_en & ~hit, or state==ERR.
  - fetch_en=0 and state!=ERR gives cpu_stall=0.
- FSM:
  - IDLE:
    - fetch_en & ~hit & ~flush -> WAIT; mem_cs<=1; mem_addr<=mapped pc; buf_tag<=pc; miss_cnt++.
    - hit -> hit_cnt++ (once per cycle of hit).
  - WAIT: mem_cs held 1 continuously; mem_addr unchanged. The memory restarts its latency if cs drops.
    - mem_stall=0 -> buf_data<=mem_dout; buf_valid<=1; mem_cs<=0; -> IDLE. The next cycle is a hit if pc is unchanged.
    - Else timeout counter++. On reaching TIMEOUT -> ERR; mem_cs<=0; err<=1.
  - ERR: terminal until rst. mem_cs=0; cpu_stall=1; flush ignored.
- Miss latency: the capture cycle is the first cycle with mem_cs=1 & mem_stall=0. inst_valid rises 1 cycle after capture. For a memory acking on the Nth cs cycle, total stall = N+1 cycles.
- mem_cs always deasserts for at least 1 cycle between transactions. Back-to-back misses are therefore separated by one idle cs cycle.
- Flush:
  - Highest priority outside ERR, in any state: buf_valid<=0, mem_cs<=0, timeout counter<=0, -> IDLE.
  - Data acked in the same cycle as flush is discarded.
  - Flush suppresses hit and hit counting that cycle.
- Flush and fetch_en together: no transaction starts that cycle. A new miss starts the next cycle if fetch_en persists.
- pc changing during WAIT is a CPU protocol violation and has undefined inst. The bench asserts pc is stable while cpu_stall=1.
- Reset mid-WAIT drops mem_cs on the next edge; the memory's own cs-low path clears its state.
- Counter wrap: 0xFFFFFFFF+1 -> 0, no flag.

Test Plan:
- Cold miss: memory model acks on 9th cs cycle with dout=0x20080005, pc=0x00000004, fetch_en=1 -> mem_addr=0x00000001, mem_cs high 9 cycles, inst_valid=1 with inst=0x20080005 in cycle 11, miss_cnt=1.
- Hit: repeat pc=0x00000004 for 3 cycles after fill -> inst_valid=1 each cycle, mem_cs=0, hit_cnt=3 (including the first post-fill cycle).
- Sequential misses: pc 0x0 then 0x4 -> two transactions, mem_cs low exactly one cycle between them, miss_cnt=2.
- Flush mid-WAIT: flush on 5th cs cycle -> mem_cs=0 next cycle, buf_valid=0. Retry of the same pc needs a full 9-cycle transaction.
- Timeout: memory never acks, TIMEOUT=32 -> err=1 after 32 WAIT cycles, mem_cs=0, cpu_stall stays 1 through flush; rst clears all.
- Fault/wrap: pc=0x00000400 (WORD_ADDR=1) -> addr_fault=1 while mem_cs=1. Preload miss_cnt=0xFFFFFFFF via force, one miss -> 0.
